// File: rtl/muxn_arb_pkg.sv
// rtl/muxn_arb_pkg.sv - shared constants and helpers for the muxn_arb selector
package muxn_arb_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

    // Index width for n sources; never narrower than one bit.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Round-robin successor of p, wrapping at n.
    function automatic int ptr_next(input int p, input int n);
        return (p >= n - 1) ? 0 : p + 1;
    endfunction

endpackage

// File: rtl/muxn_arb_rr_pick.sv
// rtl/muxn_arb_rr_pick.sv - rr_pick: first valid input at or after ptr, wrapping at N
module rr_pick
    import muxn_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = sel_width(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            grant_vld
);

    logic [N-1:0]    rot;
    logic [SELW-1:0] off;
    logic [SELW:0]   sum;

    // Rotate so ptr lands at bit 0, take the lowest set bit, then un-rotate.
    always_comb begin
        rot = N'({valid, valid} >> ptr);
        off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SELW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (SELW + 1)'(N)) begin
            sum = sum - (SELW + 1)'(N);
        end
        grant     = SELW'(sum);
        grant_vld = |valid;
    end

endmodule

// File: rtl/muxn_arb.sv
// rtl/muxn_arb.sv - N-input valid/ready selector, fixed or round-robin; MUXN_ARB_SKID_EN adds a skid entry
module muxn_arb
    import muxn_arb_pkg::*;
#(
    parameter int  WIDTH   = 32,
    parameter int  N       = 4,
    parameter int  RR_MODE = MODE_FIXED,
    localparam int SELW    = sel_width(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    input  logic [WIDTH-1:0] in_data [N],
    output logic [N-1:0]     in_ready,
    input  logic [SELW-1:0]  sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SELW-1:0]  out_src,
    input  logic             out_ready
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  rr_grant;
    logic             rr_vld;
    logic             sel_ok;
    logic [SELW-1:0]  grant;
    logic             grant_vld;
    logic             accept;
    logic             gnt_valid;
    logic [WIDTH-1:0] gnt_data;
    logic             xfer;

    rr_pick #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_pick (
        .valid     (in_valid),
        .ptr       (ptr),
        .grant     (rr_grant),
        .grant_vld (rr_vld)
    );

    // When N fills the select space every sel value names a real input.
    if ((1 << SELW) == N) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (sel < SELW'(N));
    end

    always_comb begin
        if (RR_MODE != MODE_FIXED) begin
            grant     = rr_grant;
            grant_vld = rr_vld;
        end else begin
            grant     = sel;
            grant_vld = sel_ok;
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_data  = '0;
        in_ready  = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_vld && (grant == SELW'(i))) begin
                gnt_valid   = in_valid[i];
                gnt_data    = in_data[i];
                in_ready[i] = accept;
            end
        end
    end

    assign xfer = accept && gnt_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((RR_MODE != MODE_FIXED) && xfer) begin
            ptr <= SELW'(ptr_next(int'(grant), N));
        end
    end

`ifdef MUXN_ARB_SKID_EN
    logic             skid_valid;
    logic [WIDTH-1:0] skid_data;
    logic [SELW-1:0]  skid_src;

    // Ready depends only on local state, so out_ready never reaches in_ready.
    assign accept = rst_n && !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_src   <= '0;
        end else if (out_valid && out_ready) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_src    <= skid_src;
                skid_valid <= 1'b0;
            end else if (xfer) begin
                out_data <= gnt_data;
                out_src  <= grant;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (xfer) begin
            if (out_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= gnt_data;
                skid_src   <= grant;
            end else begin
                out_valid <= 1'b1;
                out_data  <= gnt_data;
                out_src   <= grant;
            end
        end
    end
`else
    assign accept = rst_n && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// tb/tb_muxn_arb.sv - scoreboard bench: fixed-select N=5 and round-robin N=4 instances
module tb_muxn_arb;

    localparam int W  = 32;
    localparam int NF = 5;
    localparam int NR = 4;
`ifdef MUXN_ARB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [NF-1:0] f_in_valid, f_in_ready;
    logic [W-1:0]  f_in_data [NF];
    logic [2:0]    f_sel, f_out_src;
    logic          f_out_valid, f_out_ready;
    logic [W-1:0]  f_out_data;

    logic [NR-1:0] r_in_valid, r_in_ready;
    logic [W-1:0]  r_in_data [NR];
    logic [1:0]    r_sel, r_out_src;
    logic          r_out_valid, r_out_ready;
    logic [W-1:0]  r_out_data;

    muxn_arb #(.WIDTH(W), .N(NF), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_data(f_in_data),
        .in_ready(f_in_ready), .sel(f_sel), .out_valid(f_out_valid),
        .out_data(f_out_data), .out_src(f_out_src), .out_ready(f_out_ready));

    muxn_arb #(.WIDTH(W), .N(NR), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(r_in_valid), .in_data(r_in_data),
        .in_ready(r_in_ready), .sel(r_sel), .out_valid(r_out_valid),
        .out_data(r_out_data), .out_src(r_out_src), .out_ready(r_out_ready));

    typedef struct {
        logic [W-1:0] data;
        int           src;
    } item_t;

    item_t        expq0[$];
    item_t        expq1[$];
    int           nn[2] = '{NF, NR};
    bit           mv[2][5];
    logic [W-1:0] md[2][5];
    bit           ordy[2];
    int           msel;
    int           mptr[2];
    int           mocc[2];
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NF; i++) begin
            f_in_valid[i] = mv[0][i];
            f_in_data[i]  = md[0][i];
        end
        for (int i = 0; i < NR; i++) begin
            r_in_valid[i] = mv[1][i];
            r_in_data[i]  = md[1][i];
        end
        f_sel       = 3'(msel);
        r_sel       = 2'(msel);
        f_out_ready = ordy[0];
        r_out_ready = ordy[1];
    endtask

    task automatic refill(input int k, input logic [4:0] mask);
        for (int i = 0; i < nn[k]; i++) begin
            if (mask[i] && !mv[k][i]) begin
                mv[k][i] = 1'b1;
                md[k][i] = $urandom;
            end
        end
    endtask

    task automatic randomize_inputs();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < nn[k]; i++) begin
                if (!mv[k][i] && ($urandom_range(2) == 0)) begin
                    mv[k][i] = 1'b1;
                    md[k][i] = $urandom;
                end
            end
            ordy[k] = ($urandom_range(3) != 0);
        end
        msel = $urandom_range(7);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) mv[k][i] = 1'b0;
            mptr[k] = 0;
            mocc[k] = 0;
        end
        expq0.delete();
        expq1.delete();
    endtask

    // Reference: grant from the selection rules, acceptance from stage occupancy.
    task automatic step();
        int          g;
        bit          gv, acc, xf, cons;
        logic [63:0] exp_rdy;
        item_t       it;
        @(negedge clk);
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            gv = 1'b0;
            g  = 0;
            if (k == 0) begin
                g  = msel;
                gv = (msel < NF);
            end else begin
                for (int off = 0; off < NR; off++) begin
                    int idx;
                    idx = (mptr[1] + off) % NR;
                    if (!gv && mv[1][idx]) begin
                        gv = 1'b1;
                        g  = idx;
                    end
                end
            end
            acc  = SKID ? (mocc[k] < 2) : (mocc[k] == 0 || ordy[k]);
            xf   = gv && acc;
            if (xf) xf = mv[k][g];
            cons = (mocc[k] > 0) && ordy[k];
            exp_rdy = (gv && acc) ? (64'd1 << g) : 64'd0;
            if (k == 0) begin
                chk("fix_in_ready", f_in_ready, exp_rdy);
                chk("fix_out_valid", f_out_valid, mocc[0] > 0);
            end else begin
                chk("rr_in_ready", r_in_ready, exp_rdy);
                chk("rr_out_valid", r_out_valid, mocc[1] > 0);
            end
            if (xf) begin
                it.data = md[k][g];
                it.src  = g;
                if (k == 0) expq0.push_back(it);
                else        expq1.push_back(it);
                mv[k][g] = 1'b0;
                if (k == 1) mptr[1] = (g + 1) % NR;
            end
            mocc[k] = mocc[k] + int'(xf) - int'(cons);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_fix_out_valid", f_out_valid, 0);
        chk("rst_fix_out_data", f_out_data, 0);
        chk("rst_fix_out_src", f_out_src, 0);
        chk("rst_fix_in_ready", f_in_ready, 0);
        chk("rst_rr_out_valid", r_out_valid, 0);
        chk("rst_rr_out_data", r_out_data, 0);
        chk("rst_rr_out_src", r_out_src, 0);
        chk("rst_rr_in_ready", r_in_ready, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        clear_model();
        drive();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever an output is consumed.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && f_out_valid && f_out_ready) begin
                vectors++;
                if (expq0.size() == 0) begin
                    miscompares++;
                    $display("FAIL fix_spurious_out: got %0h with no transfer expected", f_out_data);
                end else begin
                    it = expq0.pop_front();
                    chk("fix_out_data", f_out_data, it.data);
                    chk("fix_out_src", f_out_src, it.src);
                end
            end
            if (rst_n && r_out_valid && r_out_ready) begin
                vectors++;
                if (expq1.size() == 0) begin
                    miscompares++;
                    $display("FAIL rr_spurious_out: got %0h with no transfer expected", r_out_data);
                end else begin
                    it = expq1.pop_front();
                    chk("rr_out_data", r_out_data, it.data);
                    chk("rr_out_src", r_out_src, it.src);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        int tries;
        clear_model();
        msel    = 0;
        ordy[0] = 1'b0;
        ordy[1] = 1'b0;
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state();
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Fixed mode: sel=2 with DEADBEEF, then sel beyond N.
        msel = 2;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        mv[0][2] = 1'b1;
        md[0][2] = 32'hDEADBEEF;
        step();
        step();
        chk("fix_deadbeef_valid", f_out_valid, 1);
        chk("fix_deadbeef_data", f_out_data, 32'hDEADBEEF);
        chk("fix_deadbeef_src", f_out_src, 2);
        msel = 7;
        refill(0, 5'h1f);
        step();
        chk("fix_sel7_in_ready", f_in_ready, 0);

        // Backpressure: three stalled cycles against a steady producer.
        do_reset();
        msel = 0;
        ordy[0] = 1'b0;
        acc_cnt = 0;
        repeat (3) begin
            refill(0, 5'h01);
            step();
            if (f_in_ready[0] && f_in_valid[0]) acc_cnt++;
        end
        chk("bp_accepted", acc_cnt, SKID ? 2 : 1);
        ordy[0] = 1'b1;
        repeat (4) begin
            refill(0, 5'h01);
            step();
        end

        // Round-robin fairness with all inputs valid and a free consumer.
        do_reset();
        ordy[1] = 1'b1;
        for (int c = 0; c < 8; c++) begin
            refill(1, 5'h0f);
            step();
            chk("rr_fair_grant", r_in_ready, 64'd1 << (c % 4));
            if (c > 0) chk("rr_fair_no_bubble", r_out_valid, 1);
        end

        // Round-robin skip over idle inputs.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            refill(1, 5'b01010);
            step();
            chk("rr_skip_grant", r_in_ready, (c % 2 == 1) ? 8 : 2);
        end

        // Random traffic with a reset landing mid-stream.
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            randomize_inputs();
            step();
            if (it == 1500) begin
                tries = 0;
                while (!r_out_valid && tries < 50) begin
                    randomize_inputs();
                    step();
                    tries++;
                end
                chk("midrst_out_valid_before", r_out_valid, 1);
                do_reset();
            end
        end

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) mv[k][i] = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (4) step();
        chk("fix_drained", expq0.size(), 0);
        chk("rr_drained", expq1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-input, valid/ready-handshaked selector with a registered output stage. It generalises the fixed 4-input combinational mux: width and input count are parameters, and the source is either chosen by an external select or by a fair round-robin arbiter. It sits between multiple producers (for example, writeback or memory-response sources) and a single consumer in the pipeline.

## Interface
- `WIDTH`, default 32: data width in bits.
- `N`, default 4: number of inputs; must be ≥ 2. Local constant `SELW = $clog2(N)`.
- `RR_MODE`, default 0: 0 selects fixed-select mode (source from `sel`); 1 selects round-robin mode (`sel` ignored).
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  N: per-input valid.
- `in_data`  in  N×WIDTH: per-input data, unpacked array `[N]`.
- `in_ready`  out  N: per-input ready; at most one bit is high in any cycle.
- `sel`  in  SELW: source index in fixed mode.
- `out_valid`  out  1: output holds valid data.
- `out_data`  out  WIDTH: registered selected data.
- `out_src`  out  SELW: index of the input that produced `out_data`.
- `out_ready`  in  1: consumer accepts the output.

## Operation
- **Grant, fixed mode:** `grant = sel`. If `sel ≥ N`, there is no grant, all `in_ready` are 0, and no transfer occurs.
- **Grant, RR mode:** search from pointer `ptr` upward, wrapping at N-1 → 0. The first index with `in_valid` set is granted. If no input is valid, there is no grant.
- **Ready:** `in_ready[i] = (i == grant) && accept`. Ready never depends on `in_valid[i]` of the same input, except for the RR search.
- **Transfer:** `in_valid[grant] && in_ready[grant]`. The stage captures `in_data[grant]` and records `grant` into `out_src`.
- **Pointer update (RR only):** on a transfer, `ptr <= (grant == N-1) ? 0 : grant + 1`. Otherwise `ptr` holds.
- **Output handshake:**
  - Output is consumed when `out_valid && out_ready`.
  - Once `out_valid` is 1, `out_data` and `out_src` are stable until consumed.
- **Input contract:** a producer holding `in_valid` must not change `in_data` until its transfer. The block does not check this.
- **Reset values:**
  - `out_valid`, `out_data`, and `out_src` are 0.
  - `ptr` is 0.
  - Skid entry is empty.
  - `in_ready` is all 0 while `rst_n` is low.
- **Reset mid-operation:** buffered data is dropped and no partial transfer is reported. The first grant after reset uses `ptr = 0`.

## Timing
- Latency is 1 cycle: a transfer at edge k makes `out_valid` high after edge k.
- Throughput is one transfer per cycle when `out_ready` is held high.
- Without skid:
  - `accept = !out_valid || out_ready`. This is a combinational path from `out_ready` to `in_ready`.
  - A simultaneous consume and new transfer in the same cycle reloads the register with no bubble.
- With skid (see Configuration):
  - `accept = !skid_valid`. There is no combinational path from `out_ready` to `in_ready`.
  - On a transfer while the output is held and not consumed, data goes to the skid entry.
  - On consume, the skid entry moves to the output.
  - When the skid entry is occupied, `accept` is 0.
- `sel` changing mid-cycle affects only the current cycle's grant. There is no hold requirement on `sel`.

## Configuration
- `MUXN_ARB_SKID_EN` defined: adds a 2-entry skid buffer (output register plus one skid entry). `in_ready` is fully registered, and full rate is maintained across a one-cycle `out_ready` stall.
- `MUXN_ARB_SKID_EN` undefined: single output register, `in_ready` combinationally gated by `out_ready`, minimum area.

## Structure
- Shared package `muxn_arb_pkg`: the `SELW` computation function and an RR pointer-increment function (wrap at N).
- One natural sub-module, `rr_pick`: combinational priority search from `ptr`, producing `grant` and `grant_vld`.
- Output and skid storage stay in the top module.

## Test plan
- **Reset:** assert `rst_n = 0` mid-stream with `out_valid = 1`. Required: `out_valid = 0`, `out_data = 0`, `ptr = 0` immediately, before any clock edge.
- **Fixed mode, N=4:** `sel = 2`, `in_valid = 4'b0100`, `in_data[2] = 32'hDEADBEEF`, `out_ready = 1`. Required: `out_data = DEADBEEF` and `out_src = 2` one cycle later. Also: N=5 with `sel = 7` gives `in_ready = 0`.
- **RR fairness:** `RR_MODE = 1`, all four inputs valid continuously, `out_ready = 1`. Required: `out_src` sequence is 0, 1, 2, 3, 0, … at one transfer per cycle.
- **RR skip:** `in_valid = 4'b1010`, `ptr = 0`. Required: grant 1, then 3, then 1.
- **Backpressure:** hold `out_ready = 0` for 3 cycles with a steady input. Required:
  - Without skid: exactly 1 item is accepted.
  - With skid: 2 items are accepted, with no loss or duplication after release.
- **Simultaneous consume and accept**, without skid: `out_valid = 1`, `out_ready = 1`, new input valid. Required: output reloads in the same edge, with no bubble cycle.
